nvram_upload: RTL

//  Read-back end of the ioctl loader path: services HPS upload requests (ioctl_upload/ioctl_rd)
//  by reading the game's battery/hiscore RAM and returning bytes on ioctl_din. Sits beside the

---
 rtl/nvram_upload_if.sv | 46 ++++
 rtl/nvram_upload.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/nvram_upload_if.sv
// Upload-side bus of the NVRAM read-back block: HPS ioctl
// read channel, CPU pause handshake and the RAM read port.
interface nvram_upload_if #(
    parameter int AW = 11,
    parameter int DW = 8
);
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic [26:0]   ioctl_addr;
    logic          ioctl_rd;
    logic [15:0]   ioctl_din;
    logic          ioctl_wait;
    logic          pause_req;
    logic          pause_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] mem_q;

    modport slave (
        input  ioctl_upload,
        input  ioctl_index,
        input  ioctl_addr,
        input  ioctl_rd,
        output ioctl_din,
        output ioctl_wait,
        output pause_req,
        input  pause_ack,
        output mem_addr,
        output mem_rd,
        input  mem_q
    );

    modport master (
        output ioctl_upload,
        output ioctl_index,
        output ioctl_addr,
        output ioctl_rd,
        input  ioctl_din,
        input  ioctl_wait,
        input  pause_req,
        output pause_ack,
        input  mem_addr,
        input  mem_rd,
        output mem_q
    );
endinterface

// File: rtl/nvram_upload.sv
// NVRAM upload: serves HPS ioctl reads from battery/hiscore RAM
// while the CPU is paused, stretching each read with ioctl_wait.
module nvram_upload #(
    parameter int          AW       = 11,
    parameter int          DW       = 8,
    parameter logic [7:0]  UP_INDEX = 8'd4
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    nvram_upload_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        READY,
        FETCH,
        CAPTURE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          pending_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   din_q;

    logic          sel;
    logic          ack;
    logic          in_range;
    logic          busy;
    logic          acc;
    logic          done;
    logic [26:0]   addr_hi;

    assign sel      = bus.ioctl_upload
                    & (bus.ioctl_index == UP_INDEX);
    assign ack      = bus.pause_ack;
    assign addr_hi  = bus.ioctl_addr >> AW;
    assign in_range = (addr_hi == '0);

    // A read owes the HPS data while fetching, or parked in HOLD
    assign busy = (state_q == FETCH)
                | (state_q == CAPTURE)
                | ((state_q == HOLD) & pending_q);

    // Strobes are taken only when the port is ours or being requested
    assign acc  = sel & bus.ioctl_rd & ~busy
                & ((state_q == READY) | (state_q == HOLD));

    // mem_q is valid in CAPTURE; commit it only if we still own RAM
    assign done = sel & (state_q == CAPTURE) & ack;

    // State register
    always_ff @(posedge clk_sys) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Latched address, pending flag and returned data
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
        end else begin
            if (!sel)
                pending_q <= 1'b0;
            else if (acc && in_range)
                pending_q <= 1'b1;
            else if (done)
                pending_q <= 1'b0;

            if (acc && in_range)
                addr_q <= bus.ioctl_addr[AW-1:0];

            if (acc && !in_range)
                din_q <= '0;
            else if (done)
                din_q <= {{(16-DW){1'b0}}, bus.mem_q};
        end
    end

    // Next state; losing sel aborts from anywhere
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sel)
                    state_d = HOLD;
            end
            HOLD: begin
                if (ack)
                    state_d = (pending_q || (acc && in_range))
                            ? FETCH : READY;
            end
            READY: begin
                if (!ack)
                    state_d = HOLD;
                else if (acc && in_range)
                    state_d = FETCH;
            end
            FETCH: begin
                state_d = ack ? CAPTURE : HOLD;
            end
            CAPTURE: begin
                state_d = ack ? READY : HOLD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!sel)
            state_d = IDLE;
    end

    // Outputs decoded from the state register
    always_comb begin
        bus.pause_req  = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.ioctl_wait = busy;
        bus.mem_addr   = addr_q;
        bus.ioctl_din  = din_q;
        unique case (state_q)
            IDLE: begin
                bus.pause_req = 1'b0;
            end
            HOLD, READY, CAPTURE: begin
                bus.pause_req = 1'b1;
            end
            FETCH: begin
                bus.pause_req = 1'b1;
                bus.mem_rd    = 1'b1;
            end
            default: begin
                bus.pause_req = 1'b0;
            end
        endcase
    end

endmodule
